// File: rtl/rca2_bist_pkg.sv
// Shared constants for the 2-bit ripple-carry adder BIST pattern generator:
// vector table, widths and controller state encoding.
package rca2_bist_pkg;

   localparam int NUM_VEC = 8;
   localparam int VEC_W   = 5;
   localparam int IDX_W   = 3;
   localparam int TMR_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   // Each entry packs {a[1], a[0], b[1], b[0], cin}.
   localparam logic [VEC_W-1:0] VEC [NUM_VEC] = '{
      5'h1C, 5'h06, 5'h11, 5'h0A,
      5'h00, 5'h19, 5'h07, 5'h1F
   };

endpackage

// File: rtl/rca2_bist_vec_rom.sv
// Combinational lookup from vector index to the packed operand vector.
module rca2_bist_vec_rom
   import rca2_bist_pkg::*;
(
   input  logic [IDX_W-1:0] i_idx,
   output logic [VEC_W-1:0] o_vec
);

   assign o_vec = VEC[i_idx];

endmodule

// File: rtl/rca2_bist_tpg.sv
// BIST sequencer: sweeps all adder test vectors, waits SETTLE cycles per
// vector, then folds the comparator mismatch into the sweep result registers.
module rca2_bist_tpg
   import rca2_bist_pkg::*;
#(
   parameter int SETTLE = 2
)
(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [7:0]         i_comp,
   output logic [IDX_W-1:0]   o_count,
   output logic [1:0]         o_a,
   output logic [1:0]         o_b,
   output logic               o_cin,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_pass,
   output logic [NUM_VEC-1:0] o_fail_mask,
   output logic [IDX_W-1:0]   o_first_fail,
   output logic               o_first_fail_vld
);

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SETTLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VEC - 1);

   state_t             r_state;
   logic [IDX_W-1:0]   r_count;
   logic [TMR_W-1:0]   r_timer;
   logic [NUM_VEC-1:0] r_fail_mask;
   logic [IDX_W-1:0]   r_first_fail;
   logic               r_first_fail_vld;
   logic               r_pass;

   logic [VEC_W-1:0]   w_vec;
   logic               w_fail;

   assign w_fail = |i_comp;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state          <= ST_IDLE;
         r_count          <= '0;
         r_timer          <= '0;
         r_fail_mask      <= '0;
         r_first_fail     <= '0;
         r_first_fail_vld <= 1'b0;
         r_pass           <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state          <= ST_APPLY;
                  r_count          <= '0;
                  r_timer          <= '0;
                  r_fail_mask      <= '0;
                  r_first_fail     <= '0;
                  r_first_fail_vld <= 1'b0;
                  r_pass           <= 1'b0;
               end
            end

            ST_APPLY: begin
               if (i_abort) begin
                  r_state <= ST_IDLE;
               end else if (r_timer == TMR_LAST) begin
                  r_state <= ST_SAMPLE;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end

            // An abort here discards the current vector's comparator result.
            ST_SAMPLE: begin
               if (i_abort) begin
                  r_state <= ST_IDLE;
               end else begin
                  if (w_fail) begin
                     r_fail_mask[r_count] <= 1'b1;
                     if (!r_first_fail_vld) begin
                        r_first_fail     <= r_count;
                        r_first_fail_vld <= 1'b1;
                     end
                  end
                  if (r_count == IDX_LAST) begin
                     // Pass is resolved here so it is already valid while done is high.
                     r_state <= ST_FINISH;
                     r_pass  <= (r_fail_mask == '0) && !w_fail;
                  end else begin
                     r_count <= r_count + 1'b1;
                     r_timer <= '0;
                     r_state <= ST_APPLY;
                  end
               end
            end

            ST_FINISH: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   rca2_bist_vec_rom u_vec_rom (
      .i_idx (r_count),
      .o_vec (w_vec)
   );

   assign o_a              = w_vec[4:3];
   assign o_b              = w_vec[2:1];
   assign o_cin            = w_vec[0];
   assign o_count          = r_count;
   assign o_busy           = (r_state == ST_APPLY) || (r_state == ST_SAMPLE);
   assign o_done           = (r_state == ST_FINISH);
   assign o_pass           = r_pass;
   assign o_fail_mask      = r_fail_mask;
   assign o_first_fail     = r_first_fail;
   assign o_first_fail_vld = r_first_fail_vld;

endmodule

// File: tb/tb_rca2_bist_tpg.sv
// Bench for rca2_bist_tpg: adder+comparator model with fault injection,
// expected sweep outcomes queued at start and compared after each sweep.
module tb_rca2_bist_tpg;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [7:0] comp;
   logic [2:0] count;
   logic [1:0] a;
   logic [1:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] fail_mask;
   logic [2:0] first_fail;
   logic       first_fail_vld;

   int n_vec  = 0;
   int n_miss = 0;

   logic [4:0] tv  [8] = '{5'h1C, 5'h06, 5'h11, 5'h0A, 5'h00, 5'h19, 5'h07, 5'h1F};
   logic [7:0] inj [8];

   typedef struct {
      logic [7:0] mask;
      logic [2:0] ff;
      logic       ffv;
      logic       pass;
      int         ndone;
      int         busy_cyc;
      int         done_at;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   rca2_bist_tpg #(.SETTLE(2)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_start          (start),
      .i_abort          (abort),
      .i_comp           (comp),
      .o_count          (count),
      .o_a              (a),
      .o_b              (b),
      .o_cin            (cin),
      .o_busy           (busy),
      .o_done           (done),
      .o_pass           (pass),
      .o_fail_mask      (fail_mask),
      .o_first_fail     (first_fail),
      .o_first_fail_vld (first_fail_vld)
   );

   // Adder under test plus golden comparator, with injected mismatches per vector.
   logic [4:0] gv;
   logic [2:0] sum;
   logic [2:0] gold;
   always_comb begin
      gv   = tv[count];
      sum  = {1'b0, a} + {1'b0, b} + {2'b00, cin};
      gold = {1'b0, gv[4:3]} + {1'b0, gv[2:1]} + {2'b00, gv[0]};
      comp = {5'b00000, sum ^ gold} | inj[count];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inj();
      for (int i = 0; i < 8; i++) inj[i] = 8'h00;
   endtask

   // Runs one sweep for 30 cycles after the start cycle and scores the outcome.
   task automatic sweep(input string tag, input bit hold, input int abort_at,
                        input logic [7:0] e_mask, input logic [2:0] e_ff,
                        input logic e_ffv, input logic e_pass,
                        input int e_ndone, input int e_busy, input int e_done_at);
      exp_t e;
      exp_t g;
      int busy_cyc;
      int ndone;
      int done_at;
      e.mask = e_mask; e.ff = e_ff; e.ffv = e_ffv; e.pass = e_pass;
      e.ndone = e_ndone; e.busy_cyc = e_busy; e.done_at = e_done_at;
      sb.push_back(e);
      busy_cyc = 0; ndone = 0; done_at = 0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (!hold || c >= 26) start = 1'b0;
         if (c == 1) begin
            chk({tag, " busy@1"}, busy, 1);
            chk({tag, " count@1"}, count, 0);
            chk({tag, " mask_clr"}, fail_mask, 0);
            chk({tag, " ffv_clr"}, first_fail_vld, 0);
            chk({tag, " pass_clr"}, pass, 0);
         end
         if (busy) begin
            busy_cyc++;
            chk({tag, " opnd"}, {a, b, cin}, tv[count]);
         end
         if (done) begin
            ndone++;
            if (done_at == 0) done_at = c;
            chk({tag, " busy_in_done"}, busy, 0);
            chk({tag, " pass_at_done"}, pass, e_pass);
         end
         abort = (abort_at != 0 && c == abort_at);
      end
      abort = 1'b0;
      g = sb.pop_front();
      chk({tag, " fail_mask"}, fail_mask, g.mask);
      chk({tag, " first_fail"}, first_fail, g.ff);
      chk({tag, " first_fail_vld"}, first_fail_vld, g.ffv);
      chk({tag, " pass"}, pass, g.pass);
      chk({tag, " done_pulses"}, ndone, g.ndone);
      chk({tag, " busy_cycles"}, busy_cyc, g.busy_cyc);
      chk({tag, " done_cycle"}, done_at, g.done_at);
      chk({tag, " idle_after"}, busy, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      clear_inj();
      repeat (3) @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst pass", pass, 0);
      chk("rst mask", fail_mask, 0);
      chk("rst ffv", first_fail_vld, 0);
      chk("rst ff", first_fail, 0);
      chk("rst count", count, 0);
      chk("rst opnd", {a, b, cin}, 5'h1C);
      rst_n = 1'b1;
      @(negedge clk);

      sweep("clean", 1'b0, 0, 8'h00, 3'd0, 1'b0, 1'b1, 1, 24, 25);

      inj[3] = 8'h01;
      sweep("v3", 1'b0, 0, 8'h08, 3'd3, 1'b1, 1'b0, 1, 24, 25);

      clear_inj();
      inj[2] = 8'h30;
      inj[6] = 8'h80;
      sweep("dbl", 1'b0, 0, 8'h44, 3'd2, 1'b1, 1'b0, 1, 24, 25);

      clear_inj();
      inj[5] = 8'h04;
      sweep("hold", 1'b1, 0, 8'h20, 3'd5, 1'b1, 1'b0, 1, 24, 25);

      clear_inj();
      sweep("after_hold", 1'b0, 0, 8'h00, 3'd0, 1'b0, 1'b1, 1, 24, 25);

      inj[1] = 8'h02;
      sweep("abort", 1'b0, 10, 8'h02, 3'd1, 1'b1, 1'b0, 0, 10, 0);

      // Reset mid-sweep after a failure has been recorded.
      clear_inj();
      inj[0] = 8'h10;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk("pre_rst mask", fail_mask, 8'h01);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst busy", busy, 0);
      chk("mid_rst count", count, 0);
      chk("mid_rst mask", fail_mask, 0);
      chk("mid_rst ffv", first_fail_vld, 0);
      chk("mid_rst ff", first_fail, 0);
      chk("mid_rst pass", pass, 0);
      chk("mid_rst done", done, 0);
      chk("mid_rst opnd", {a, b, cin}, 5'h1C);
      clear_inj();
      sweep("post_rst", 1'b0, 0, 8'h00, 3'd0, 1'b0, 1'b1, 1, 24, 25);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
